// File: rtl/next_pc.sv
// Program counter: registered current PC plus combinational next-PC select.
// Build option NEXT_PC_REL_BRANCH_EN: a taken branch adds target as a signed offset.
module next_pc #(
  parameter int unsigned D = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [D-1:0] start_address,
  input  logic         branch,
  input  logic         taken,
  input  logic [D-1:0] target,
  output logic [D-1:0] prog_ctr_next,
  output logic [D-1:0] prog_ctr_out
);

  logic [D-1:0] r_pc;
  logic [D-1:0] w_inc;
  logic [D-1:0] w_branch_pc;
  logic [D-1:0] w_next;

  // Both sums truncate to D bits, giving modulo-2^D wrap with no carry out.
  assign w_inc = r_pc + {{(D-1){1'b0}}, 1'b1};

`ifdef NEXT_PC_REL_BRANCH_EN
  assign w_branch_pc = r_pc + target;
`else
  assign w_branch_pc = target;
`endif

  // Nested if/else keeps unselected inputs out of the result path.
  always_comb begin
    w_next = w_inc;
    if (start) begin
      w_next = start_address;
    end else if (branch) begin
      if (taken) begin
        w_next = w_branch_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_next;
    end
  end

  assign prog_ctr_next = w_next;
  assign prog_ctr_out  = r_pc;

endmodule

// File: tb/tb_next_pc.sv
// Self-checking bench for next_pc: directed scenarios plus randomized control,
// checked every cycle against an arithmetic reference model.
module tb_next_pc;
  localparam int unsigned D = 12;
  localparam int unsigned M = 1 << D;

  logic         clk = 1'b0;
  logic         clk_run = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [D-1:0] start_address = '0;
  logic         branch = 1'b0;
  logic         taken = 1'b0;
  logic [D-1:0] target = '0;
  logic [D-1:0] prog_ctr_next;
  logic [D-1:0] prog_ctr_out;

  int n_pass = 0;
  int n_total = 0;
  int unsigned model_pc = 0;

  next_pc #(.D(D)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_address (start_address),
    .branch        (branch),
    .taken         (taken),
    .target        (target),
    .prog_ctr_next (prog_ctr_next),
    .prog_ctr_out  (prog_ctr_out)
  );

  always #5 if (clk_run) clk = ~clk;

  function automatic int unsigned model_next(int unsigned pc);
    if (start) return int'(start_address);
    if (branch && taken) begin
`ifdef NEXT_PC_REL_BRANCH_EN
      return (pc + int'(target)) % M;
`else
      return int'(target);
`endif
    end
    return (pc + 1) % M;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_pc = 0;
    else model_pc = model_next(model_pc);
  end

  always @(negedge clk) begin
    if (rst_n && clk_run) begin
      chk("pc_out", prog_ctr_out, model_pc);
      chk("pc_next", prog_ctr_next, model_next(model_pc));
    end
  end

  // Apply controls (called at posedge+2), then advance one edge.
  task automatic cyc(input logic s, input int unsigned sa, input logic b,
                     input logic t, input int unsigned tg);
    start = s; start_address = sa[D-1:0];
    branch = b; taken = t; target = tg[D-1:0];
    @(posedge clk); #2;
  endtask

  initial begin
    // Asynchronous reset with the clock stopped.
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out", prog_ctr_out, 0);
    chk("async_rst_next", prog_ctr_next, 1);
    #1 rst_n = 1'b1;
    clk_run = 1'b1;
    @(posedge clk); #2;
    chk("lit_after_rst_1", prog_ctr_out, 1);
    cyc(0, 0, 0, 0, 0);
    chk("lit_after_rst_2", prog_ctr_out, 2);
    cyc(0, 0, 0, 0, 0);
    chk("lit_after_rst_3", prog_ctr_out, 3);

    cyc(1, 0, 0, 0, 0);
    chk("lit_start0", prog_ctr_out, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit_start0_inc", prog_ctr_out, 1);
    cyc(1, 128, 0, 0, 0);
    chk("lit_start128", prog_ctr_out, 128);
    cyc(0, 0, 0, 0, 0);
    chk("lit_start128_inc", prog_ctr_out, 129);
    cyc(0, 0, 1, 0, 77);
    chk("lit_br_not_taken", prog_ctr_out, 130);
    cyc(0, 0, 0, 1, 77);
    chk("lit_taken_alone", prog_ctr_out, 131);

`ifndef NEXT_PC_REL_BRANCH_EN
    cyc(0, 0, 1, 1, 16);
    chk("lit_taken16", prog_ctr_out, 16);
    cyc(0, 0, 1, 1, 2);
    chk("lit_taken2", prog_ctr_out, 2);
    cyc(0, 0, 1, 1, 2);
    chk("lit_taken2_hold", prog_ctr_out, 2);
`else
    cyc(1, 10, 0, 0, 0);
    cyc(0, 0, 1, 1, 4094);
    chk("lit_rel_minus2", prog_ctr_out, 8);
    cyc(0, 0, 1, 1, 5);
    chk("lit_rel_plus5", prog_ctr_out, 13);
`endif

    cyc(1, 128, 1, 1, 16);
    chk("lit_priority", prog_ctr_out, 128);
    cyc(1, 300, 0, 0, 0);
    cyc(1, 300, 0, 0, 0);
    chk("lit_start_hold", prog_ctr_out, 300);
    cyc(1, 4095, 0, 0, 0);
    chk("lit_wrap_top", prog_ctr_out, 4095);
    cyc(0, 0, 0, 0, 0);
    chk("lit_wrap_zero", prog_ctr_out, 0);

    // Reset asserted mid-sequence with a pending start request.
    start = 1'b1; start_address = 12'd999;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", prog_ctr_out, 0);
    chk("mid_rst_next", prog_ctr_next, 999);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("lit_after_mid_rst", prog_ctr_out, 999);

    for (int unsigned i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) == 0), $urandom_range(0, M - 1),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, M - 1));
    end

    @(negedge clk);
    clk_run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
